// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external ALU among NREQ requesters with a valid/ready response channel.
// Ports: clk_i/rst_ni clock and async active-low reset; req_valid_i/req_ready_o/req_op_i/req_a_i/req_b_i
// packed per-requester request channel; alu_operand0_o/alu_operand1_o/alu_op_o/alu_data_i/alu_bru_exp_i
// external ALU; rsp_valid_o/rsp_ready_i/rsp_id_o/rsp_data_o/rsp_bru_o response channel; busy_o not idle.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module alu_arbiter #(
  parameter int n = 32,
  parameter int NREQ = 2,
  parameter int ALU_LAT = 1,
  parameter int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NREQ-1:0]  req_valid_i,
  output logic [NREQ-1:0]  req_ready_o,
  input  logic [4*NREQ-1:0] req_op_i,
  input  logic [n*NREQ-1:0] req_a_i,
  input  logic [n*NREQ-1:0] req_b_i,
  output logic [n-1:0]     alu_operand0_o,
  output logic [n-1:0]     alu_operand1_o,
  output logic [3:0]       alu_op_o,
  input  logic [n-1:0]     alu_data_i,
  input  logic             alu_bru_exp_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [IDW-1:0]   rsp_id_o,
  output logic [n-1:0]     rsp_data_o,
  output logic             rsp_bru_o,
  output logic             busy_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  state_e         state_q;
  logic [IDW-1:0] last_q, id_q, rsp_id_q, win, idx;
  logic [3:0]     op_q, cnt_q;
  logic [n-1:0]   a_q, b_q, rsp_data_q;
  logic           rsp_valid_q, rsp_bru_q, found, arb_en, fire;
  // With last_q frozen at NREQ-1 the scan starts at 0, which gives the fixed-priority variant for free.
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDW'((int'(last_q) + i) % NREQ);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign arb_en = rst_ni && (state_q == IDLE || (state_q == RESP && rsp_ready_i));
  assign fire = arb_en && found;
  assign req_ready_o = fire ? NREQ'(1) << win : '0;
  assign alu_op_o = op_q;
  assign alu_operand0_o = a_q;
  assign alu_operand1_o = b_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o = rsp_id_q;
  assign rsp_data_o = rsp_data_q;
  assign rsp_bru_o = rsp_bru_q;
  assign busy_o = state_q != IDLE;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q <= IDW'(NREQ - 1);
      id_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_data_q <= '0;
      rsp_bru_q <= 1'b0;
    end else begin
      if (state_q == RESP && rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
        state_q <= IDLE;
      end
      if (state_q == EXEC) begin
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'(ALU_LAT - 1)) begin
          rsp_data_q <= alu_data_i;
          rsp_bru_q <= alu_bru_exp_i;
          rsp_id_q <= id_q;
          rsp_valid_q <= 1'b1;
          state_q <= RESP;
        end
      end
      if (fire) begin
        op_q <= req_op_i[4*int'(win) +: 4];
        a_q <= req_a_i[n*int'(win) +: n];
        b_q <= req_b_i[n*int'(win) +: n];
        id_q <= win;
        cnt_q <= '0;
        state_q <= EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_q <= win;
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a behavioural ALU stub.
module tb_alu_arbiter;
  typedef struct {int id; logic [31:0] d; logic b;} rsp_t;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [1:0] v1, r1, v3, r3;
  logic [7:0] op1, op3;
  logic [63:0] a1, b1, a3, b3;
  logic rdy1, rdy3;
  logic [31:0] ao0_1, ao1_1, ad1, rd1, ao0_3, ao1_3, ad3, rd3;
  logic [3:0] aop1, aop3;
  logic rv1, rid1, rb1, busy1, rv3, rid3, rb3, busy3;
  int tests = 0, fails = 0, exp_last = 1, g;
  rsp_t sb[$];
  rsp_t exp_r;

  function automatic logic [31:0] alu_f(logic [3:0] o, logic [31:0] x, logic [31:0] y);
    case (o)
      4'h0: return x + y;
      4'h1: return x & y;
      4'h2: return x | y;
      4'h3: return x ^ y;
      4'h4: return x << y[4:0];
      4'h5: return x >> y[4:0];
      4'h6: return {31'b0, $signed(x) < $signed(y)};
      4'h7: return {31'b0, x < y};
      4'h8: return x - y;
      4'hd: return $signed(x) >>> y[4:0];
      default: return 32'h0;
    endcase
  endfunction

  assign ad1 = alu_f(aop1, ao0_1, ao1_1);
  assign ad3 = alu_f(aop3, ao0_3, ao1_3);

  alu_arbiter #(.n(32), .NREQ(2), .ALU_LAT(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v1), .req_ready_o(r1), .req_op_i(op1),
    .req_a_i(a1), .req_b_i(b1), .alu_operand0_o(ao0_1), .alu_operand1_o(ao1_1), .alu_op_o(aop1),
    .alu_data_i(ad1), .alu_bru_exp_i(|ad1), .rsp_valid_o(rv1), .rsp_ready_i(rdy1), .rsp_id_o(rid1),
    .rsp_data_o(rd1), .rsp_bru_o(rb1), .busy_o(busy1));

  alu_arbiter #(.n(32), .NREQ(2), .ALU_LAT(3)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v3), .req_ready_o(r3), .req_op_i(op3),
    .req_a_i(a3), .req_b_i(b3), .alu_operand0_o(ao0_3), .alu_operand1_o(ao1_3), .alu_op_o(aop3),
    .alu_data_i(ad3), .alu_bru_exp_i(|ad3), .rsp_valid_o(rv3), .rsp_ready_i(rdy3), .rsp_id_o(rid3),
    .rsp_data_o(rd3), .rsp_bru_o(rb3), .busy_o(busy3));

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set1(int k, logic [3:0] o, logic [31:0] x, logic [31:0] y);
    if (k == 0) begin op1[3:0] = o; a1[31:0] = x; b1[31:0] = y; end
    else begin op1[7:4] = o; a1[63:32] = x; b1[63:32] = y; end
  endtask

  task automatic push(int id, logic [31:0] d);
    sb.push_back('{id, d, |d});
  endtask

  function automatic int pick(logic [1:0] v, int last);
    int k;
`ifdef ALU_ARB_FIXED_PRIO_EN
    k = last;
    return v[0] ? 0 : v[1] ? 1 : -1;
`else
    for (int i = 1; i <= 2; i++) begin
      k = (last + i) % 2;
      if (v[k[0]]) return k;
    end
    return -1;
`endif
  endfunction

  function automatic logic [31:0] exp_of(int k);
    return k == 0 ? alu_f(op1[3:0], a1[31:0], b1[31:0]) : alu_f(op1[7:4], a1[63:32], b1[63:32]);
  endfunction

  always begin
    @(negedge clk);
    #2;
    if (rst_n && rv1 && rdy1) begin
      if (sb.size() == 0) chk("sb_unexpected_rsp", 1, 0);
      else begin
        exp_r = sb.pop_front();
        chk("rsp_id", rid1, exp_r.id);
        chk("rsp_data", rd1, exp_r.d);
        chk("rsp_bru", rb1, exp_r.b);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v1 = 0; op1 = 0; a1 = 0; b1 = 0; rdy1 = 0;
    v3 = 0; op3 = 0; a3 = 0; b3 = 0; rdy3 = 0;
    tick(); tick();
    chk("rst_rsp_valid", rv1, 0);
    chk("rst_ready", r1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_alu_op", aop1, 0);
    chk("rst_opnd0", ao0_1, 0);
    chk("rst_rsp_data", rd1, 0);
    rst_n = 1;
    tick();
    set1(0, 4'h0, 5, 7);
    v1 = 2'b01;
    #1;
    chk("t1_ready", r1, 2'b01);
    push(0, 32'd12);
    exp_last = 0;
    tick();
    v1 = 0;
    #1;
    chk("t1_busy", busy1, 1);
    chk("t1_alu_op", aop1, 0);
    chk("t1_opnd0", ao0_1, 5);
    chk("t1_opnd1", ao1_1, 7);
    chk("t1_rsp_early", rv1, 0);
    chk("t1_exec_ready", r1, 0);
    tick();
    chk("t1_rsp_valid", rv1, 1);
    chk("t1_rsp_data", rd1, 12);
    chk("t1_rsp_id", rid1, 0);
    chk("t1_rsp_bru", rb1, 1);
    chk("t1_opnd0_hold", ao0_1, 5);
    rdy1 = 1;
    tick();
    chk("t1_rsp_clear", rv1, 0);
    chk("t1_idle", busy1, 0);
    for (int i = 0; i < 6; i++) begin
      set1(0, 4'h0, i, 100);
      set1(1, (i % 3 == 0) ? 4'ha : 4'hd, 32'h8000_0000, i);
      v1 = 2'b11;
      #1;
      g = pick(v1, exp_last);
      chk("rr_ready", r1, 64'(1) << g);
      push(g, exp_of(g));
      exp_last = g;
      tick();
      chk("rr_exec_ready", r1, 0);
      chk("rr_busy", busy1, 1);
      chk("rr_alu_op", aop1, g == 0 ? op1[3:0] : op1[7:4]);
      if (i == 5) v1 = 0;
      tick();
    end
    tick();
    chk("rr_idle", busy1, 0);
    rdy1 = 0;
    set1(0, 4'h8, 3, 3);
    v1 = 2'b01;
    #1;
    chk("bp_ready", r1, 2'b01);
    push(0, 0);
    exp_last = 0;
    tick();
    v1 = 0;
    set1(1, 4'h0, 1, 2);
    tick();
    v1 = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", rv1, 1);
      chk("bp_data", rd1, 0);
      chk("bp_bru", rb1, 0);
      chk("bp_ready_blocked", r1, 0);
      tick();
    end
    rdy1 = 1;
    #1;
    chk("bp_b2b_ready", r1, 2'b10);
    push(1, 3);
    exp_last = 1;
    tick();
    v1 = 0;
    #1;
    chk("bp_b2b_rsp_clear", rv1, 0);
    chk("bp_b2b_busy", busy1, 1);
    chk("bp_b2b_opnd0", ao0_1, 1);
    tick();
    tick();
    chk("bp_idle", busy1, 0);
    rdy1 = 0;
    set1(0, 4'h3, 32'hF0, 32'h0F);
    v1 = 2'b01;
    tick();
    v1 = 0;
    tick();
    v1 = 2'b11;
    #1;
    chk("pre_rst_valid", rv1, 1);
    chk("pre_rst_ready", r1, 0);
    chk("pre_rst_alu_op", aop1, 3);
    rst_n = 0;
    #1;
    chk("arst_rsp_valid", rv1, 0);
    chk("arst_ready", r1, 0);
    chk("arst_busy", busy1, 0);
    chk("arst_alu_op", aop1, 0);
    chk("arst_rsp_data", rd1, 0);
    tick(); tick();
    rst_n = 1;
    exp_last = 1;
    #1;
    g = pick(v1, exp_last);
    chk("arst_first_grant", r1, 2'b01);
    push(g, exp_of(g));
    exp_last = g;
    rdy1 = 1;
    tick();
    v1 = 0;
    tick();
    tick();
    chk("arst_idle", busy1, 0);
    a3[31:0] = 32'h8000_0000;
    b3[31:0] = 4;
    op3[3:0] = 4'hd;
    v3 = 2'b01;
    #1;
    chk("lat3_ready", r3, 2'b01);
    tick();
    v3 = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lat3_alu_op", aop3, 4'hd);
      chk("lat3_opnd0", ao0_3, 32'h8000_0000);
      chk("lat3_opnd1", ao1_3, 4);
      chk("lat3_rsp_early", rv3, 0);
      chk("lat3_busy", busy3, 1);
      tick();
    end
    chk("lat3_rsp_valid", rv3, 1);
    chk("lat3_rsp_data", rd3, 32'hF800_0000);
    chk("lat3_rsp_bru", rb3, 1);
    chk("lat3_rsp_id", rid3, 0);
    rdy3 = 1;
    tick();
    chk("lat3_rsp_clear", rv3, 0);
    chk("lat3_idle", busy3, 0);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
